// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment scan controller for the front panel.
// Binary two-digit fields are clamped to 99 and converted to BCD by a
// sequential subtract-by-ten engine. Results are committed atomically to the
// display register file, which is scanned one-hot by a free-running prescaler.
// Optional per-field blink is enabled by defining SEG_BLINK_EN.
module seg_scan_ctrl #(
    parameter int N_FIELD      = 4,
    parameter int SCAN_DIV     = 32768,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [8*N_FIELD-1:0]   field_bin,
    input  logic                   load,
    input  logic [N_FIELD-1:0]     blink_mask,
    output logic                   busy,
    output logic [2*N_FIELD-1:0]   dig_sel,
    output logic [3:0]             value,
    output logic                   blank
);
    localparam int N_DIG = 2 * N_FIELD;
    localparam int PW    = (N_FIELD > 1) ? $clog2(N_FIELD) : 1;
    localparam int IW    = $clog2(N_DIG);
    localparam int CW    = $clog2(SCAN_DIV);
    localparam logic [N_DIG-1:0] SEL_RST = {1'b1, {(N_DIG-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CAPTURE, CONV, COMMIT} state_t;

    state_t         state_q;
    logic           pending_q;
    logic           busy_q;
    logic [PW-1:0]  ptr_q;
    logic [6:0]     rem_q;
    logic [3:0]     tens_q;
    logic [6:0]     sbin_q [N_FIELD];
    logic [3:0]     shd_q  [N_DIG];
    logic [3:0]     dig_q  [N_DIG];

    logic [CW-1:0]    pre_q;
    logic [IW-1:0]    idx_q;
    logic [IW-1:0]    idx_d;
    logic             wrap;
    logic             frame_end;
    logic [N_DIG-1:0] sel_d;
    logic [N_DIG-1:0] dig_sel_q;
    logic [3:0]       digit_d;
    logic [3:0]       value_q;
    logic             blank_d;
    logic             blank_q;

    function automatic logic [6:0] clamp99(input logic [7:0] b);
        return (b > 8'd99) ? 7'd99 : b[6:0];
    endfunction

    // Conversion FSM: capture, subtract-by-ten per field, atomic commit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
            ptr_q     <= '0;
            rem_q     <= '0;
            tens_q    <= '0;
            for (int unsigned k = 0; k < N_FIELD; k++) sbin_q[k] <= '0;
            for (int unsigned i = 0; i < N_DIG; i++) begin
                shd_q[i] <= '0;
                dig_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (load) begin
                        state_q <= CAPTURE;
                        busy_q  <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (load) pending_q <= 1'b1;
                    for (int unsigned k = 0; k < N_FIELD; k++)
                        sbin_q[k] <= clamp99(field_bin[8*k +: 8]);
                    rem_q   <= clamp99(field_bin[7:0]);
                    tens_q  <= '0;
                    ptr_q   <= '0;
                    state_q <= CONV;
                end
                CONV: begin
                    if (load) pending_q <= 1'b1;
                    if (rem_q >= 7'd10) begin
                        rem_q  <= rem_q - 7'd10;
                        tens_q <= tens_q + 4'd1;
                    end else begin
                        for (int unsigned k = 0; k < N_FIELD; k++) begin
                            if (ptr_q == PW'(k)) begin
                                shd_q[N_DIG-2-2*k] <= tens_q;
                                shd_q[N_DIG-1-2*k] <= rem_q[3:0];
                            end
                        end
                        for (int unsigned k = 1; k < N_FIELD; k++) begin
                            if (ptr_q == PW'(k-1)) rem_q <= sbin_q[k];
                        end
                        tens_q <= '0;
                        if (ptr_q == PW'(N_FIELD-1)) state_q <= COMMIT;
                        else                         ptr_q   <= ptr_q + PW'(1);
                    end
                end
                COMMIT: begin
                    for (int unsigned i = 0; i < N_DIG; i++) dig_q[i] <= shd_q[i];
                    if (pending_q || load) begin
                        state_q   <= CAPTURE;
                        pending_q <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Next scan index, one-hot select and the digit that will be shown
    always_comb begin
        wrap      = (pre_q == CW'(SCAN_DIV-1));
        idx_d     = idx_q;
        frame_end = 1'b0;
        if (wrap) begin
            if (idx_q == IW'(N_DIG-1)) begin
                idx_d     = '0;
                frame_end = 1'b1;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end
        sel_d = '0;
        for (int unsigned i = 0; i < N_DIG; i++) sel_d[N_DIG-1-i] = (idx_d == IW'(i));
        // Forward the shadow during COMMIT so the new digit shows one cycle later
        digit_d = (state_q == COMMIT) ? shd_q[idx_d] : dig_q[idx_d];
    end

`ifdef SEG_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [BW-1:0] bcnt_q;
    logic          phase_q;
    logic          phase_d;
    logic          fmask;

    // Blink phase toggles after BLINK_FRAMES completed frames; 1 = lit
    always_comb begin
        phase_d = phase_q;
        if (frame_end && (bcnt_q == BW'(BLINK_FRAMES-1))) phase_d = ~phase_q;
        fmask = 1'b0;
        for (int unsigned k = 0; k < N_FIELD; k++) begin
            if ((idx_d == IW'(N_DIG-2-2*k)) || (idx_d == IW'(N_DIG-1-2*k)))
                fmask = blink_mask[k];
        end
        blank_d = ~phase_d & fmask;
    end

    // Frame counter and phase register for blink
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcnt_q  <= '0;
            phase_q <= 1'b1;
        end else if (frame_end) begin
            bcnt_q  <= (bcnt_q == BW'(BLINK_FRAMES-1)) ? '0 : bcnt_q + BW'(1);
            phase_q <= phase_d;
        end
    end
`else
    localparam int unused_blink_frames = BLINK_FRAMES;
    logic unused_blink_mask;

    // Blink removed: mask ignored, digits never dark
    always_comb begin
        unused_blink_mask = ^blink_mask;
        blank_d           = 1'b0;
    end
`endif

    // Free-running prescaler, scan index and registered display outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q     <= '0;
            idx_q     <= '0;
            dig_sel_q <= SEL_RST;
            value_q   <= '0;
            blank_q   <= 1'b0;
        end else begin
            pre_q     <= wrap ? '0 : pre_q + CW'(1);
            idx_q     <= idx_d;
            dig_sel_q <= sel_d;
            value_q   <= blank_d ? 4'hF : digit_d;
            blank_q   <= blank_d;
        end
    end

    assign busy    = busy_q;
    assign dig_sel = dig_sel_q;
    assign value   = value_q;
    assign blank   = blank_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed bench for seg_scan_ctrl with a scoreboard of
// expected busy lengths and display digits. Small SCAN_DIV/BLINK_FRAMES keep
// the scan fast; blink expectations follow SEG_BLINK_EN.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;
    localparam int N_FIELD      = 4;
    localparam int N_DIG        = 8;
    localparam int SCAN_DIV     = 4;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME        = SCAN_DIV * N_DIG;
`ifdef SEG_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] cycles;
        logic [31:0] digs;
    } exp_t;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        load       = 1'b0;
    logic [31:0] field_bin  = '0;
    logic [3:0]  blink_mask = '0;
    logic        busy;
    logic [7:0]  dig_sel;
    logic [3:0]  value;
    logic        blank;

    int          n_assert = 0;
    int          n_fail   = 0;
    int unsigned since_rst = 0;
    logic [31:0] cur_digs  = '0;
    exp_t        sb[$];

    seg_scan_ctrl #(
        .N_FIELD(N_FIELD),
        .SCAN_DIV(SCAN_DIV),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .field_bin(field_bin),
        .load(load),
        .blink_mask(blink_mask),
        .busy(busy),
        .dig_sel(dig_sel),
        .value(value),
        .blank(blank)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) since_rst <= 0;
        else        since_rst <= since_rst + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] digs_of(input logic [31:0] f);
        logic [31:0] d;
        d = '0;
        for (int k = 0; k < N_FIELD; k++) begin
            int v;
            v = int'(f[8*k +: 8]);
            if (v > 99) v = 99;
            d[4*(N_DIG-2-2*k) +: 4] = 4'(v / 10);
            d[4*(N_DIG-1-2*k) +: 4] = 4'(v % 10);
        end
        return d;
    endfunction

    function automatic int conv_cycles(input logic [31:0] f);
        int s;
        s = 0;
        for (int k = 0; k < N_FIELD; k++) begin
            int v;
            v = int'(f[8*k +: 8]);
            if (v > 99) v = 99;
            s += v / 10 + 1;
        end
        return s;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic do_load(input logic [31:0] f, input bit push);
        @(posedge clk); #1;
        field_bin = f;
        load      = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        if (push) sb.push_back('{cycles: 32'(conv_cycles(f) + 2), digs: digs_of(f)});
    endtask

    // Scan position and blink phase follow from the cycle count since reset
    task automatic scan_check(input logic [31:0] digs, input logic [3:0] mask,
                              input int ncyc, input string tag);
        for (int c = 0; c < ncyc; c++) begin
            int unsigned t, idx, frame;
            bit          bl;
            @(negedge clk);
            t     = since_rst;
            idx   = (t / SCAN_DIV) % N_DIG;
            frame = t / FRAME;
            bl    = BLINK_ON && (((frame / BLINK_FRAMES) % 2) == 1) && mask[(N_DIG-1-idx)/2];
            check({tag, "_dig_sel"}, 32'(dig_sel), 32'h80 >> idx);
            check({tag, "_blank"},   32'(blank),   32'(bl));
            check({tag, "_value"},   32'(value),   bl ? 32'hF : 32'(digs[4*idx +: 4]));
        end
    endtask

    task automatic wait_done(input string tag, input logic [3:0] mask);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        e = sb.pop_front();
        check({tag, "_busy_cycles"}, 32'(n), e.cycles);
        cur_digs = e.digs;
        scan_check(e.digs, mask, FRAME + 4, tag);
    endtask

    initial begin
        logic [31:0] fa, fb, da, db;
        int          n;

        // Reset state and free-running scan
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_dig_sel", 32'(dig_sel), 32'h40 >> 0 << 1);
        check("rst_value",   32'(value),   32'h0);
        check("rst_blank",   32'(blank),   32'h0);
        check("rst_busy",    32'(busy),    32'h0);
        scan_check(32'h0, 4'b0000, FRAME + SCAN_DIV, "rst_scan");

        // Basic conversion {3:45, 2:7, 1:99, 0:0}
        do_load({8'd45, 8'd7, 8'd99, 8'd0}, 1'b1);
        wait_done("conv", 4'b0000);

        // Clamp field 0 = 200, mixed others
        do_load({8'd12, 8'd34, 8'd56, 8'd200}, 1'b1);
        wait_done("clamp", 4'b0000);

        // Boundaries: 10, 9, 90, 255
        do_load({8'd10, 8'd9, 8'd90, 8'd255}, 1'b1);
        wait_done("bound", 4'b0000);

        // All zero: shortest conversion
        do_load(32'h0, 1'b1);
        wait_done("zero", 4'b0000);
        do_load({8'd21, 8'd43, 8'd65, 8'd87}, 1'b1);
        wait_done("pre_pend", 4'b0000);

        // Pending: second load 5 cycles after the first, exactly one restart
        fa = {8'd98, 8'd87, 8'd76, 8'd65};
        fb = {8'd11, 8'd22, 8'd33, 8'd44};
        da = digs_of(fa);
        db = digs_of(fb);
        sb.push_back('{cycles: 32'(conv_cycles(fa) + conv_cycles(fb) + 4), digs: db});
        do_load(fa, 1'b0);
        n = 0;
        for (int c = 0; c < 300; c++) begin
            int unsigned idx;
            bit          ok;
            @(negedge clk);
            if (busy !== 1'b1) break;
            n++;
            idx = (since_rst / SCAN_DIV) % N_DIG;
            ok  = (value === cur_digs[4*idx +: 4]) || (value === da[4*idx +: 4]) ||
                  (value === db[4*idx +: 4]);
            check("pend_no_partial", 32'(ok), 32'h1);
            if (c == 4) begin
                field_bin = fb;
                load      = 1'b1;
            end else begin
                load = 1'b0;
            end
        end
        load = 1'b0;
        begin
            exp_t e;
            e = sb.pop_front();
            check("pend_busy_cycles", 32'(n), e.cycles);
            cur_digs = e.digs;
            scan_check(e.digs, 4'b0000, FRAME + 4, "pend");
        end

        // Reset in CONV cycle 4: digits cleared, no later COMMIT
        do_load({8'd99, 8'd99, 8'd99, 8'd99}, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            check("midrst_busy", 32'(busy), 32'h0);
        end
        scan_check(32'h0, 4'b0000, FRAME + 4, "midrst");

        // Blink on field 0 across several frames from a fresh reset
        do_reset();
        blink_mask = 4'b0001;
        do_load({8'd12, 8'd34, 8'd56, 8'd78}, 1'b1);
        wait_done("blink_load", 4'b0001);
        scan_check(cur_digs, 4'b0001, 5 * FRAME, "blink");
        blink_mask = 4'b0000;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
